// File: rtl/ysyx_22041207_hazard_ctrl_if.sv
// ----------------------------------------------------------------------------
// ysyx_22041207_hazard_ctrl_if
//
// Bundles the hazard sources seen by the stall controller and the hold/clear
// controls it drives into the pipeline registers and the PC.
//
// Signal summary:
//   id_rs1addr / id_rs2addr    source registers of the instruction in ID
//   id_rs1_used / id_rs2_used  ID instruction actually reads rs1 / rs2
//   ex_memoryReadWen           instruction in EX is a load
//   ex_rwaddr                  destination register of the instruction in EX
//   ex_redirect                EX resolved a control-flow change
//   mdu_start / mdu_done       multi-cycle mul/div issue and completion
//   mem_req / mem_ready        MEM stage request and LSU completion
//   pc_stall                   hold PC
//   if_id_bubble / _flush      hold / clear IF_ID
//   id_ex_bubble / _flush      hold / clear ID_EX
//   ex_mem_bubble / _flush     hold / clear EX_MEM
//   mem_timeout                sticky LSU timeout error
//   stall_cnt / flush_cnt      performance counters (zero when not built in)
//
// Modports:
//   master  the hazard controller (consumes sources, drives controls)
//   slave   the pipeline side (drives sources, consumes controls)
// ----------------------------------------------------------------------------
interface ysyx_22041207_hazard_ctrl_if;

    // Hazard sources
    logic [4:0]  id_rs1addr;
    logic [4:0]  id_rs2addr;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic        ex_memoryReadWen;
    logic [4:0]  ex_rwaddr;
    logic        ex_redirect;
    logic        mdu_start;
    logic        mdu_done;
    logic        mem_req;
    logic        mem_ready;

    // Pipeline controls
    logic        pc_stall;
    logic        if_id_bubble;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic        id_ex_flush;
    logic        ex_mem_bubble;
    logic        ex_mem_flush;

    // Status
    logic        mem_timeout;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    modport master (
        input  id_rs1addr,
        input  id_rs2addr,
        input  id_rs1_used,
        input  id_rs2_used,
        input  ex_memoryReadWen,
        input  ex_rwaddr,
        input  ex_redirect,
        input  mdu_start,
        input  mdu_done,
        input  mem_req,
        input  mem_ready,
        output pc_stall,
        output if_id_bubble,
        output if_id_flush,
        output id_ex_bubble,
        output id_ex_flush,
        output ex_mem_bubble,
        output ex_mem_flush,
        output mem_timeout,
        output stall_cnt,
        output flush_cnt
    );

    modport slave (
        output id_rs1addr,
        output id_rs2addr,
        output id_rs1_used,
        output id_rs2_used,
        output ex_memoryReadWen,
        output ex_rwaddr,
        output ex_redirect,
        output mdu_start,
        output mdu_done,
        output mem_req,
        output mem_ready,
        input  pc_stall,
        input  if_id_bubble,
        input  if_id_flush,
        input  id_ex_bubble,
        input  id_ex_flush,
        input  ex_mem_bubble,
        input  ex_mem_flush,
        input  mem_timeout,
        input  stall_cnt,
        input  flush_cnt
    );

endinterface

// File: rtl/ysyx_22041207_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// ysyx_22041207_hazard_ctrl
//
// Pipeline hazard/stall controller. Detects load-use hazards, EX-stage
// redirects, LSU memory waits and multi-cycle MDU operations, and sequences
// the hold (bubble) and clear (flush) controls of IF_ID, ID_EX, EX_MEM and PC.
//
// Ports:
//   clk  clock, all state updates on posedge
//   rst  synchronous reset, active-high; forces all controls to 0
//   hz   ysyx_22041207_hazard_ctrl_if.master (sources in, controls out)
//
// Parameters:
//   FLUSH_CYCLES  cycles IF_ID/ID_EX are cleared after a redirect (1..15)
//   MEM_TIMEOUT   wait cycles in MEM_WAIT before mem_timeout sets (1..65535)
//
// Optional build macro:
//   HAZARD_PERF_EN  when defined, stall_cnt / flush_cnt count cycles with
//                   pc_stall / if_id_flush high; otherwise both read 0.
//
// Control outputs are combinational from state and inputs so a hazard takes
// effect in the cycle it is seen. State, counters and mem_timeout are flops.
// ----------------------------------------------------------------------------
module ysyx_22041207_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT  = 1023
) (
    input logic                        clk,
    input logic                        rst,
    ysyx_22041207_hazard_ctrl_if.master hz
);

    typedef enum logic [1:0] {
        StRun,
        StMemWait,
        StMduWait,
        StFlush
    } state_e;

    localparam logic [3:0]  FlushInit    = 4'(FLUSH_CYCLES - 1);
    localparam logic [15:0] TimeoutLimit = 16'(MEM_TIMEOUT);
    localparam logic [15:0] WaitMax      = 16'hFFFF;

    state_e      state_q, state_d;
    logic [3:0]  fcnt_q, fcnt_d;
    logic [15:0] wcnt_q, wcnt_d;
    logic        timeout_q, timeout_d;

    // Raw controls before reset gating
    logic pc_stall_c;
    logic if_id_bubble_c;
    logic if_id_flush_c;
    logic id_ex_bubble_c;
    logic id_ex_flush_c;
    logic ex_mem_bubble_c;
    logic ex_mem_flush_c;

    // Gated controls actually driven out
    logic pc_stall;
    logic if_id_bubble;
    logic if_id_flush;
    logic id_ex_bubble;
    logic id_ex_flush;
    logic ex_mem_bubble;
    logic ex_mem_flush;

    // ------------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------------
    logic rs1_hit;
    logic rs2_hit;
    logic load_use;
    logic mem_stall;

    assign rs1_hit = hz.id_rs1_used && (hz.id_rs1addr == hz.ex_rwaddr);
    assign rs2_hit = hz.id_rs2_used && (hz.id_rs2addr == hz.ex_rwaddr);

    // x0 is never a real dependency
    assign load_use = hz.ex_memoryReadWen && (hz.ex_rwaddr != 5'd0) && (rs1_hit || rs2_hit);

    assign mem_stall = hz.mem_req && !hz.mem_ready;

    // ------------------------------------------------------------------------
    // Next state and raw controls
    // ------------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        fcnt_d          = fcnt_q;
        wcnt_d          = wcnt_q;
        pc_stall_c      = 1'b0;
        if_id_bubble_c  = 1'b0;
        if_id_flush_c   = 1'b0;
        id_ex_bubble_c  = 1'b0;
        id_ex_flush_c   = 1'b0;
        ex_mem_bubble_c = 1'b0;
        ex_mem_flush_c  = 1'b0;

        unique case (state_q)
            StRun: begin
                if (mem_stall) begin
                    // Freeze everything behind MEM until the LSU answers
                    pc_stall_c      = 1'b1;
                    if_id_bubble_c  = 1'b1;
                    id_ex_bubble_c  = 1'b1;
                    ex_mem_bubble_c = 1'b1;
                    state_d         = StMemWait;
                    wcnt_d          = 16'd1;
                end else if (hz.ex_redirect) begin
                    if_id_flush_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = StFlush;
                        fcnt_d  = FlushInit;
                    end
                end else if (hz.mdu_start) begin
                    // EX_MEM is cleared rather than held so the MDU op does
                    // not retire twice while it computes
                    pc_stall_c     = 1'b1;
                    if_id_bubble_c = 1'b1;
                    id_ex_bubble_c = 1'b1;
                    ex_mem_flush_c = 1'b1;
                    state_d        = StMduWait;
                end else if (load_use) begin
                    // One-cycle bubble into EX so the load data can forward
                    pc_stall_c     = 1'b1;
                    if_id_bubble_c = 1'b1;
                    id_ex_flush_c  = 1'b1;
                end
            end

            StMemWait: begin
                if (!hz.mem_ready) begin
                    pc_stall_c      = 1'b1;
                    if_id_bubble_c  = 1'b1;
                    id_ex_bubble_c  = 1'b1;
                    ex_mem_bubble_c = 1'b1;
                    if (wcnt_q != WaitMax) begin
                        wcnt_d = wcnt_q + 16'd1;
                    end
                end else begin
                    // Other hazards are held stable upstream and picked up in RUN
                    state_d = StRun;
                    wcnt_d  = 16'd0;
                end
            end

            StMduWait: begin
                if (!hz.mdu_done) begin
                    pc_stall_c     = 1'b1;
                    if_id_bubble_c = 1'b1;
                    id_ex_bubble_c = 1'b1;
                    ex_mem_flush_c = 1'b1;
                end else begin
                    state_d = StRun;
                end
            end

            StFlush: begin
                if_id_flush_c = 1'b1;
                id_ex_flush_c = 1'b1;
                // fcnt counts flush cycles still owed, this one included
                if (fcnt_q <= 4'd1) begin
                    state_d = StRun;
                    fcnt_d  = 4'd0;
                end else begin
                    fcnt_d = fcnt_q - 4'd1;
                end
            end

            default: begin
                state_d = StRun;
                fcnt_d  = 4'd0;
                wcnt_d  = 16'd0;
            end
        endcase
    end

    // Sticky once the wait counter reaches the limit while still waiting
    assign timeout_d = timeout_q || ((state_d == StMemWait) && (wcnt_d >= TimeoutLimit));

    // ------------------------------------------------------------------------
    // Reset gating of the controls
    // ------------------------------------------------------------------------
    always_comb begin
        pc_stall      = pc_stall_c;
        if_id_bubble  = if_id_bubble_c;
        if_id_flush   = if_id_flush_c;
        id_ex_bubble  = id_ex_bubble_c;
        id_ex_flush   = id_ex_flush_c;
        ex_mem_bubble = ex_mem_bubble_c;
        ex_mem_flush  = ex_mem_flush_c;
        if (rst) begin
            pc_stall      = 1'b0;
            if_id_bubble  = 1'b0;
            if_id_flush   = 1'b0;
            id_ex_bubble  = 1'b0;
            id_ex_flush   = 1'b0;
            ex_mem_bubble = 1'b0;
            ex_mem_flush  = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StRun;
            fcnt_q    <= 4'd0;
            wcnt_q    <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fcnt_q    <= fcnt_d;
            wcnt_q    <= wcnt_d;
            timeout_q <= timeout_d;
        end
    end

    // ------------------------------------------------------------------------
    // Optional performance counters
    // ------------------------------------------------------------------------
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (pc_stall) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (if_id_flush) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
`else
    assign hz.stall_cnt = 32'd0;
    assign hz.flush_cnt = 32'd0;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign hz.pc_stall      = pc_stall;
    assign hz.if_id_bubble  = if_id_bubble;
    assign hz.if_id_flush   = if_id_flush;
    assign hz.id_ex_bubble  = id_ex_bubble;
    assign hz.id_ex_flush   = id_ex_flush;
    assign hz.ex_mem_bubble = ex_mem_bubble;
    assign hz.ex_mem_flush  = ex_mem_flush;
    assign hz.mem_timeout   = timeout_q;

endmodule

// File: tb/tb_ysyx_22041207_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// Bench for ysyx_22041207_hazard_ctrl with FLUSH_CYCLES=3, MEM_TIMEOUT=8.
// Directed scenarios compare against hand-derived control patterns; the
// random scenario compares against a cycle-level reference model.
// Control vector order: {pc_stall, if_id_bubble, if_id_flush, id_ex_bubble,
//                        id_ex_flush, ex_mem_bubble, ex_mem_flush}
// ----------------------------------------------------------------------------
module tb_ysyx_22041207_hazard_ctrl;

    localparam int unsigned FlushCycles = 3;
    localparam int unsigned MemTimeout  = 8;

    localparam logic [6:0] CtlIdle    = 7'b0000000;
    localparam logic [6:0] CtlMemHold = 7'b1101010;
    localparam logic [6:0] CtlFlush   = 7'b0010100;
    localparam logic [6:0] CtlMdu     = 7'b1101001;
    localparam logic [6:0] CtlLoadUse = 7'b1100100;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    // Reference model state
    bit          m_mem_busy;
    bit          m_mdu_busy;
    bit          m_timeout;
    int unsigned m_waits;
    int unsigned m_flush_left;
    logic [31:0] m_stalls;
    logic [31:0] m_flushes;

    ysyx_22041207_hazard_ctrl_if hz ();

    ysyx_22041207_hazard_ctrl #(
        .FLUSH_CYCLES(FlushCycles),
        .MEM_TIMEOUT (MemTimeout)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hz (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] actual_ctl();
        return {hz.pc_stall, hz.if_id_bubble, hz.if_id_flush, hz.id_ex_bubble,
                hz.id_ex_flush, hz.ex_mem_bubble, hz.ex_mem_flush};
    endfunction

    // Expected controls for the current cycle from the model and live inputs
    function automatic logic [6:0] model_ctl();
        logic lu;
        lu = hz.ex_memoryReadWen && (hz.ex_rwaddr != 5'd0) &&
             ((hz.id_rs1_used && hz.id_rs1addr == hz.ex_rwaddr) ||
              (hz.id_rs2_used && hz.id_rs2addr == hz.ex_rwaddr));
        if (rst) return CtlIdle;
        if (m_mem_busy) return hz.mem_ready ? CtlIdle : CtlMemHold;
        if (m_mdu_busy) return hz.mdu_done ? CtlIdle : CtlMdu;
        if (m_flush_left > 0) return CtlFlush;
        if (hz.mem_req && !hz.mem_ready) return CtlMemHold;
        if (hz.ex_redirect) return CtlFlush;
        if (hz.mdu_start) return CtlMdu;
        if (lu) return CtlLoadUse;
        return CtlIdle;
    endfunction

    function automatic logic [31:0] exp_stall_cnt();
`ifdef HAZARD_PERF_EN
        return m_stalls;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] exp_flush_cnt();
`ifdef HAZARD_PERF_EN
        return m_flushes;
`else
        return 32'd0;
`endif
    endfunction

    // Advance the model by one clock using the inputs currently driven
    task automatic model_tick();
        logic [6:0] e;
        e = model_ctl();
        if (rst) begin
            m_mem_busy   = 0;
            m_mdu_busy   = 0;
            m_timeout    = 0;
            m_waits      = 0;
            m_flush_left = 0;
            m_stalls     = 32'd0;
            m_flushes    = 32'd0;
            return;
        end
        if (e[6]) m_stalls = m_stalls + 32'd1;
        if (e[4]) m_flushes = m_flushes + 32'd1;
        if (m_mem_busy) begin
            if (hz.mem_ready) begin
                m_mem_busy = 0;
                m_waits    = 0;
            end else begin
                if (m_waits < 65535) m_waits++;
                if (m_waits >= MemTimeout) m_timeout = 1;
            end
        end else if (m_mdu_busy) begin
            if (hz.mdu_done) m_mdu_busy = 0;
        end else if (m_flush_left > 0) begin
            m_flush_left--;
        end else if (hz.mem_req && !hz.mem_ready) begin
            m_mem_busy = 1;
            m_waits    = 1;
            if (m_waits >= MemTimeout) m_timeout = 1;
        end else if (hz.ex_redirect) begin
            m_flush_left = FlushCycles - 1;
        end else if (hz.mdu_start) begin
            m_mdu_busy = 1;
        end
    endtask

    task automatic advance();
        model_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        hz.id_rs1addr       = 5'd0;
        hz.id_rs2addr       = 5'd0;
        hz.id_rs1_used      = 1'b0;
        hz.id_rs2_used      = 1'b0;
        hz.ex_memoryReadWen = 1'b0;
        hz.ex_rwaddr        = 5'd0;
        hz.ex_redirect      = 1'b0;
        hz.mdu_start        = 1'b0;
        hz.mdu_done         = 1'b0;
        hz.mem_req          = 1'b0;
        hz.mem_ready        = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst            = 1'b1;
        hz.mem_req     = 1'b1;
        hz.ex_redirect = 1'b1;
        hz.mdu_start   = 1'b1;
        advance();
        @(negedge clk);
        checks++;
        if (actual_ctl() !== CtlIdle) begin
            errors++;
            $display("FAIL reset_ctl got %b want %b", actual_ctl(), CtlIdle);
        end
        advance();
        @(negedge clk);
        checks++;
        if (hz.mem_timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_timeout got %b want 0", hz.mem_timeout);
        end
        checks++;
        if (hz.stall_cnt !== 32'd0 || hz.flush_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_perf got %0d/%0d want 0/0", hz.stall_cnt, hz.flush_cnt);
        end
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        checks++;
        if (actual_ctl() !== CtlIdle) begin
            errors++;
            $display("FAIL reset_release got %b want %b", actual_ctl(), CtlIdle);
        end
        advance();
    endtask

    task automatic test_load_use();
        logic [6:0] want;
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            unique case (i)
                0: begin  // load x5, ID reads x5 via rs2
                    hz.ex_memoryReadWen = 1'b1; hz.ex_rwaddr = 5'd5;
                    hz.id_rs1addr = 5'd7; hz.id_rs1_used = 1'b1;
                    hz.id_rs2addr = 5'd5; hz.id_rs2_used = 1'b1;
                    want = CtlLoadUse;
                end
                1: begin  // bubble now in EX
                    hz.id_rs2addr = 5'd5; hz.id_rs2_used = 1'b1;
                    want = CtlIdle;
                end
                2: begin  // load to x0 never stalls
                    hz.ex_memoryReadWen = 1'b1; hz.ex_rwaddr = 5'd0;
                    hz.id_rs2addr = 5'd0; hz.id_rs2_used = 1'b1;
                    want = CtlIdle;
                end
                3: begin  // rs1 dependency
                    hz.ex_memoryReadWen = 1'b1; hz.ex_rwaddr = 5'd12;
                    hz.id_rs1addr = 5'd12; hz.id_rs1_used = 1'b1;
                    hz.id_rs2addr = 5'd3; hz.id_rs2_used = 1'b1;
                    want = CtlLoadUse;
                end
                default: begin  // matching address but operand unused
                    hz.ex_memoryReadWen = 1'b1; hz.ex_rwaddr = 5'd12;
                    hz.id_rs1addr = 5'd12; hz.id_rs2addr = 5'd12;
                    want = CtlIdle;
                end
            endcase
            @(negedge clk);
            checks++;
            if (actual_ctl() !== want) begin
                errors++;
                $display("FAIL load_use c%0d got %b want %b", i, actual_ctl(), want);
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_redirect();
        logic [6:0] want;
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            hz.ex_redirect = (i == 0);
            want = (i < 3) ? CtlFlush : CtlIdle;
            @(negedge clk);
            checks++;
            if (actual_ctl() !== want) begin
                errors++;
                $display("FAIL redirect c%0d got %b want %b", i, actual_ctl(), want);
            end
            advance();
        end
    endtask

    task automatic test_mem_wait();
        logic [6:0] want;
        for (int i = 0; i < 9; i++) begin
            idle_inputs();
            hz.mem_req     = (i <= 4);
            hz.mem_ready   = (i == 4);
            hz.ex_redirect = (i <= 5);
            if (i < 4)       want = CtlMemHold;
            else if (i == 4) want = CtlIdle;
            else if (i < 8)  want = CtlFlush;
            else             want = CtlIdle;
            @(negedge clk);
            checks++;
            if (actual_ctl() !== want || hz.mem_timeout !== 1'b0) begin
                errors++;
                $display("FAIL mem_wait c%0d got %b/%b want %b/0", i, actual_ctl(),
                         hz.mem_timeout, want);
            end
            advance();
        end
    endtask

    task automatic test_timeout();
        logic [6:0] want;
        logic       want_to;
        for (int i = 0; i < 13; i++) begin
            idle_inputs();
            rst          = (i == 11);
            hz.mem_req   = (i <= 9);
            hz.mem_ready = (i == 9);
            want    = (i <= 8) ? CtlMemHold : CtlIdle;
            want_to = (i >= 8 && i <= 11);
            @(negedge clk);
            checks++;
            if (actual_ctl() !== want || hz.mem_timeout !== want_to) begin
                errors++;
                $display("FAIL timeout c%0d got %b/%b want %b/%b", i, actual_ctl(),
                         hz.mem_timeout, want, want_to);
            end
            advance();
        end
        rst = 1'b0;
    endtask

    task automatic test_mdu();
        logic [6:0] want;
        for (int i = 0; i < 7; i++) begin
            idle_inputs();
            hz.mdu_start = (i == 0);
            hz.mdu_done  = (i == 0 || i == 5);  // done with start is ignored
            want = (i < 5) ? CtlMdu : CtlIdle;
            @(negedge clk);
            checks++;
            if (actual_ctl() !== want) begin
                errors++;
                $display("FAIL mdu c%0d got %b want %b", i, actual_ctl(), want);
            end
            advance();
        end
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            hz.mdu_start = (i == 0);
            rst          = (i == 2);
            want = (i < 2) ? CtlMdu : CtlIdle;
            @(negedge clk);
            checks++;
            if (actual_ctl() !== want) begin
                errors++;
                $display("FAIL mdu_reset c%0d got %b want %b", i, actual_ctl(), want);
            end
            advance();
        end
        rst = 1'b0;
    endtask

    task automatic test_perf();
        logic [31:0] want_s;
        logic [31:0] want_f;
        idle_inputs();
        rst = 1'b1;
        advance();
        rst = 1'b0;
        // 3 flush cycles, then one load-use stall cycle
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            hz.ex_redirect = (i == 0);
            if (i == 3) begin
                hz.ex_memoryReadWen = 1'b1; hz.ex_rwaddr = 5'd9;
                hz.id_rs1addr = 5'd9; hz.id_rs1_used = 1'b1;
            end
            advance();
        end
        idle_inputs();
`ifdef HAZARD_PERF_EN
        want_s = 32'd1;
        want_f = 32'd3;
`else
        want_s = 32'd0;
        want_f = 32'd0;
`endif
        @(negedge clk);
        checks++;
        if (hz.stall_cnt !== want_s || hz.flush_cnt !== want_f) begin
            errors++;
            $display("FAIL perf got %0d/%0d want %0d/%0d", hz.stall_cnt, hz.flush_cnt,
                     want_s, want_f);
        end
        advance();
    endtask

    task automatic test_random();
        logic [6:0] want;
        for (int i = 0; i < 3000; i++) begin
            rst                 = ($urandom_range(0, 63) == 0);
            hz.id_rs1addr       = 5'($urandom_range(0, 7));
            hz.id_rs2addr       = 5'($urandom_range(0, 7));
            hz.id_rs1_used      = 1'($urandom_range(0, 1));
            hz.id_rs2_used      = 1'($urandom_range(0, 1));
            hz.ex_memoryReadWen = 1'($urandom_range(0, 1));
            hz.ex_rwaddr        = 5'($urandom_range(0, 7));
            hz.ex_redirect      = ($urandom_range(0, 7) == 0);
            hz.mdu_start        = ($urandom_range(0, 7) == 0);
            hz.mdu_done         = ($urandom_range(0, 3) == 0);
            hz.mem_req          = ($urandom_range(0, 3) == 0);
            hz.mem_ready        = ($urandom_range(0, 2) == 0);
            want = model_ctl();
            @(negedge clk);
            checks++;
            if (actual_ctl() !== want) begin
                errors++;
                $display("FAIL rand_ctl c%0d got %b want %b", i, actual_ctl(), want);
            end
            checks++;
            if (hz.mem_timeout !== m_timeout) begin
                errors++;
                $display("FAIL rand_timeout c%0d got %b want %b", i, hz.mem_timeout, m_timeout);
            end
            checks++;
            if (hz.stall_cnt !== exp_stall_cnt()) begin
                errors++;
                $display("FAIL rand_stall_cnt c%0d got %0d want %0d", i, hz.stall_cnt,
                         exp_stall_cnt());
            end
            checks++;
            if (hz.flush_cnt !== exp_flush_cnt()) begin
                errors++;
                $display("FAIL rand_flush_cnt c%0d got %0d want %0d", i, hz.flush_cnt,
                         exp_flush_cnt());
            end
            advance();
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        m_mem_busy   = 0;
        m_mdu_busy   = 0;
        m_timeout    = 0;
        m_waits      = 0;
        m_flush_left = 0;
        m_stalls     = 32'd0;
        m_flushes    = 32'd0;
        rst          = 1'b1;
        idle_inputs();

        test_reset();
        test_load_use();
        test_redirect();
        test_mem_wait();
        test_timeout();
        test_mdu();
        test_perf();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
